instr_fetch_spi: RTL and testbench

Instruction-fetch reader on the far side of the program counter: takes the 16-bit byte address the PC presents, reads one 16-bit instruction from an external SPI flash/SRAM (READ command, mode 0), and returns it with a one-cycle valid strobe. It sits between the PC/sequencer and the chip's SPI pins. One fetch is in flight at a time; the sequencer waits for `instr_valid_out` before updating the PC.

---
 rtl/instr_fetch_spi.sv | 107 ++++++++++
 tb/tb_instr_fetch_spi.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_spi.sv
// Instruction-fetch reader: shifts a READ command plus 24-bit address out over
// SPI mode 0 and assembles the returned 16-bit big-endian instruction word.
module instr_fetch_spi #(
  parameter logic [7:0] READ_CMD     = 8'h03,
  parameter logic [7:0] ADDR_HI_BYTE = 8'h00
) (
  input  logic        clk_in,
  input  logic        reset_in,
  input  logic [15:0] fetch_addr_in,
  input  logic        fetch_req_in,
  output logic        fetch_busy_out,
  output logic [15:0] instr_out,
  output logic        instr_valid_out,
  output logic        spi_cs_n_out,
  output logic        spi_sck_out,
  output logic        spi_mosi_out,
  input  logic        spi_miso_in
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic [5:0] LAST_BIT  = 6'd47;
  localparam logic [5:0] FIRST_RX  = 6'd32;

  state_t      state_q, state_d;
  logic [5:0]  bit_q, bit_d;
  logic        phase_q, phase_d;   // 0: sck low half, 1: sck high half
  logic [47:0] tx_q, tx_d;
  logic [15:0] rx_q, rx_d;
  logic [15:0] instr_q, instr_d;
  logic        valid_q, valid_d;

  always_comb begin
    // NOTE: every next-state value gets a default first so no path infers a latch.
    state_d = state_q;
    bit_d   = bit_q;
    phase_d = phase_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    instr_d = instr_q;
    valid_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (fetch_req_in) begin
          state_d = SHIFT;
          bit_d   = '0;
          phase_d = 1'b0;
          tx_d    = {READ_CMD, ADDR_HI_BYTE, fetch_addr_in[15:1], 1'b0, 16'h0000};
        end
      end
      SHIFT: begin
        if (!phase_q) begin
          phase_d = 1'b1;
        end else begin
          phase_d = 1'b0;
          tx_d    = {tx_q[46:0], 1'b0};
          if (bit_q >= FIRST_RX) rx_d = {rx_q[14:0], spi_miso_in};
          if (bit_q == LAST_BIT) begin
            // Clearing tx here leaves mosi low for the whole idle period.
            state_d = IDLE;
            bit_d   = '0;
            tx_d    = '0;
            instr_d = {rx_q[14:0], spi_miso_in};
            valid_d = 1'b1;
          end else begin
            bit_d = bit_q + 6'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state_q <= IDLE;
      bit_q   <= '0;
      phase_q <= 1'b0;
      tx_q    <= '0;
      rx_q    <= '0;
      instr_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      phase_q <= phase_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

  // Every output is a flop or a single-flop buffer, so none can glitch.
  assign spi_cs_n_out    = (state_q == IDLE);
  assign fetch_busy_out  = (state_q == SHIFT);
  assign spi_sck_out     = phase_q;
  assign spi_mosi_out    = tx_q[47];
  assign instr_out       = instr_q;
  assign instr_valid_out = valid_q;

endmodule

// File: tb/tb_instr_fetch_spi.sv
// Self-checking bench for instr_fetch_spi: behavioural SPI memory, expected
// words queued at request time and compared when the valid strobe appears.
module tb_instr_fetch_spi;

  logic        clk = 1'b0;
  logic        reset_in = 1'b1;
  logic [15:0] fetch_addr_in = '0;
  logic        fetch_req_in = 1'b0;
  logic        fetch_busy_out, instr_valid_out;
  logic [15:0] instr_out;
  logic        spi_cs_n_out, spi_sck_out, spi_mosi_out;
  logic        spi_miso_in = 1'b0;

  logic [15:0] addr_hi = '0;
  logic        req_hi = 1'b0;
  logic        busy_hi, valid_hi, cs_n_hi, sck_hi, mosi_hi;
  logic [15:0] instr_hi;

  int checks = 0;
  int failures = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  instr_fetch_spi u_dut (
    .clk_in(clk), .reset_in(reset_in), .fetch_addr_in(fetch_addr_in),
    .fetch_req_in(fetch_req_in), .fetch_busy_out(fetch_busy_out),
    .instr_out(instr_out), .instr_valid_out(instr_valid_out),
    .spi_cs_n_out(spi_cs_n_out), .spi_sck_out(spi_sck_out),
    .spi_mosi_out(spi_mosi_out), .spi_miso_in(spi_miso_in)
  );

  instr_fetch_spi #(.READ_CMD(8'h03), .ADDR_HI_BYTE(8'h7F)) u_dut_hi (
    .clk_in(clk), .reset_in(reset_in), .fetch_addr_in(addr_hi),
    .fetch_req_in(req_hi), .fetch_busy_out(busy_hi),
    .instr_out(instr_hi), .instr_valid_out(valid_hi),
    .spi_cs_n_out(cs_n_hi), .spi_sck_out(sck_hi),
    .spi_mosi_out(mosi_hi), .spi_miso_in(1'b1)
  );

  // Memory contents: big-endian word at an even byte address.
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    if (a == 16'h1234) return 16'hA53C;
    return {a[7:0] ^ 8'h5A, a[7:0] ^ 8'hC3};
  endfunction

  // SPI memory model: captures MOSI on sck rise, drives MISO on sck fall.
  logic [47:0] frame = '0, last_frame = '0;
  int          rises = 0, last_rises = 0;
  logic [15:0] resp = '0;

  always @(negedge spi_cs_n_out or posedge spi_sck_out) begin
    if (spi_sck_out) begin
      frame = {frame[46:0], spi_mosi_out};
      rises = rises + 1;
      if (rises == 32) resp = mem_word(frame[15:0]);
    end else begin
      frame = '0;
      rises = 0;
    end
  end

  always @(negedge spi_sck_out)
    spi_miso_in = (rises >= 32 && rises < 48) ? resp[47 - rises] : 1'b0;

  always @(posedge spi_cs_n_out) begin
    last_frame = frame;
    last_rises = rises;
  end

  logic [47:0] frame_hi = '0;
  int          rises_hi = 0;
  always @(posedge sck_hi) begin
    frame_hi = {frame_hi[46:0], mosi_hi};
    rises_hi = rises_hi + 1;
  end

  // Present a request so that it is sampled at the following rising edge (edge T).
  task automatic start_fetch(input logic [15:0] a, input bit expect_word);
    @(negedge clk);
    fetch_addr_in = a;
    fetch_req_in  = 1'b1;
    if (expect_word) exp_q.push_back(mem_word({a[15:1], 1'b0}));
    @(posedge clk);
  endtask

  // Observe cycles T+1..T+n at mid-cycle; pops the scoreboard on each valid pulse.
  task automatic watch(input int n, input int drop_k, input int extra_k,
                       input logic [15:0] extra_addr, input int cs_win,
                       output int vcnt, output int v1, output int v2, output int csh);
    logic [15:0] e;
    vcnt = 0; v1 = 0; v2 = 0; csh = 0;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      if (instr_valid_out) begin
        vcnt++;
        if (v1 == 0) v1 = k; else if (v2 == 0) v2 = k;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_valid cycle=%0d instr=%h expected no pulse", k, instr_out);
        end else begin
          e = exp_q.pop_front();
          if (instr_out !== e) begin
            failures++;
            $display("FAIL instr_word cycle=%0d got=%h expected=%h", k, instr_out, e);
          end
        end
      end
      if (k <= cs_win && spi_cs_n_out) csh++;
      if (k == drop_k) fetch_req_in = 1'b0;
      if (extra_k != 0 && k == extra_k) begin
        fetch_req_in  = 1'b1;
        fetch_addr_in = extra_addr;
      end
      if (extra_k != 0 && k == extra_k + 1) fetch_req_in = 1'b0;
    end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({spi_cs_n_out, spi_sck_out, spi_mosi_out, fetch_busy_out, instr_valid_out} !== 5'b10000
        || instr_out !== 16'h0000) begin
      failures++;
      $display("FAIL reset_values cs_n/sck/mosi/busy/valid=%b instr=%h expected 10000 0000",
               {spi_cs_n_out, spi_sck_out, spi_mosi_out, fetch_busy_out, instr_valid_out}, instr_out);
    end
    @(negedge clk);
    reset_in = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single();
    int vcnt, v1, v2, csh;
    start_fetch(16'h1235, 1'b1);
    watch(110, 1, 0, 16'h0, 96, vcnt, v1, v2, csh);
    checks++;
    if (vcnt != 1 || v1 != 97) begin
      failures++;
      $display("FAIL single_valid pulses=%0d at=%0d expected 1 at 97", vcnt, v1);
    end
    checks++;
    if (csh != 0) begin
      failures++;
      $display("FAIL single_cs_low cs_high_cycles=%0d expected 0 in T+1..T+96", csh);
    end
    checks++;
    if (last_frame[47:16] !== 32'h03001234) begin
      failures++;
      $display("FAIL single_frame got=%h expected=03001234", last_frame[47:16]);
    end
    checks++;
    if (last_rises != 48) begin
      failures++;
      $display("FAIL single_sck_edges got=%0d expected=48", last_rises);
    end
    checks++;
    if (instr_out !== 16'hA53C || spi_sck_out !== 1'b0 || spi_mosi_out !== 1'b0) begin
      failures++;
      $display("FAIL single_hold instr=%h sck=%b mosi=%b expected a53c 0 0",
               instr_out, spi_sck_out, spi_mosi_out);
    end
  endtask

  task automatic test_ignore_busy();
    int vcnt, v1, v2, csh;
    start_fetch(16'h1235, 1'b1);
    watch(200, 1, 10, 16'h0040, 96, vcnt, v1, v2, csh);
    checks++;
    if (vcnt != 1 || v1 != 97) begin
      failures++;
      $display("FAIL ignore_valid pulses=%0d at=%0d expected 1 at 97", vcnt, v1);
    end
    checks++;
    if (last_frame[47:16] !== 32'h03001234 || last_rises != 48) begin
      failures++;
      $display("FAIL ignore_frame got=%h edges=%0d expected=03001234 edges=48",
               last_frame[47:16], last_rises);
    end
  endtask

  task automatic test_back_to_back();
    int vcnt, v1, v2, csh;
    start_fetch(16'h0000, 1'b1);
    #1;
    fetch_addr_in = 16'h0002;
    exp_q.push_back(mem_word(16'h0002));
    watch(200, 98, 0, 16'h0, 193, vcnt, v1, v2, csh);
    checks++;
    if (vcnt != 2 || v1 != 97 || v2 != 194) begin
      failures++;
      $display("FAIL b2b_valid pulses=%0d at=%0d,%0d expected 2 at 97,194", vcnt, v1, v2);
    end
    checks++;
    if (csh != 1) begin
      failures++;
      $display("FAIL b2b_cs_gap cs_high_cycles=%0d expected 1", csh);
    end
    checks++;
    if (last_frame[47:16] !== 32'h03000002) begin
      failures++;
      $display("FAIL b2b_frame got=%h expected=03000002", last_frame[47:16]);
    end
  endtask

  task automatic test_mid_reset();
    int vcnt, v1, v2, csh;
    start_fetch(16'h1234, 1'b0);
    fetch_req_in = 1'b0;
    repeat (39) @(negedge clk);
    reset_in = 1'b1;
    #1;
    checks++;
    if ({spi_cs_n_out, spi_sck_out, spi_mosi_out, fetch_busy_out, instr_valid_out} !== 5'b10000
        || instr_out !== 16'h0000) begin
      failures++;
      $display("FAIL midreset_values cs_n/sck/mosi/busy/valid=%b instr=%h expected 10000 0000",
               {spi_cs_n_out, spi_sck_out, spi_mosi_out, fetch_busy_out, instr_valid_out}, instr_out);
    end
    @(negedge clk);
    reset_in = 1'b0;
    watch(10, 0, 0, 16'h0, 0, vcnt, v1, v2, csh);
    checks++;
    if (vcnt != 0 || instr_out !== 16'h0000) begin
      failures++;
      $display("FAIL midreset_no_valid pulses=%0d instr=%h expected 0 0000", vcnt, instr_out);
    end
    start_fetch(16'h00A0, 1'b1);
    watch(110, 1, 0, 16'h0, 96, vcnt, v1, v2, csh);
    checks++;
    if (vcnt != 1 || v1 != 97 || csh != 0) begin
      failures++;
      $display("FAIL midreset_refetch pulses=%0d at=%0d cs_high=%0d expected 1 97 0", vcnt, v1, csh);
    end
  endtask

  task automatic test_addr_param();
    int v = 0;
    @(negedge clk);
    addr_hi = 16'hFFFF;
    req_hi  = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 110; k++) begin
      @(negedge clk);
      if (k == 1) req_hi = 1'b0;
      if (valid_hi && v == 0) v = k;
    end
    checks++;
    if (v != 97 || instr_hi !== 16'hFFFF) begin
      failures++;
      $display("FAIL param_word at=%0d instr=%h expected 97 ffff", v, instr_hi);
    end
    checks++;
    if (frame_hi[47:16] !== 32'h037FFFFE || rises_hi != 48) begin
      failures++;
      $display("FAIL param_frame got=%h edges=%0d expected=037ffffe edges=48",
               frame_hi[47:16], rises_hi);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_ignore_busy();
    test_back_to_back();
    test_mid_reset();
    test_addr_param();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain pending=%0d expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
